// File: rtl/fm_ctrl_pkg.sv
// Shared definitions for the FM transmitter configuration sequencer:
// sequencer states and configuration select codes.
package fm_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAMP    = 3'd1,
        RAMP_DN = 3'd2,
        TUNE    = 3'd3,
        SETTLE  = 3'd4,
        RAMP_UP = 3'd5
    } state_e;

    localparam logic [1:0] SEL_FREQ  = 2'd0;
    localparam logic [1:0] SEL_AGAIN = 2'd1;
    localparam logic [1:0] SEL_PGAIN = 2'd2;
    localparam logic [1:0] SEL_MUTE  = 2'd3;

endpackage

// File: rtl/gain_slew.sv
// One slewed 16-bit gain: on each tick moves toward the target by at most
// RAMP_STEP, clamping at the target so it never overshoots or wraps.
module gain_slew #(
    parameter logic [15:0] RAMP_STEP = 16'd64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_tick,
    input  logic [15:0] i_target,
    output logic [15:0] o_cur,
    output logic        o_at_target
);

    logic [15:0] cur_r;
    logic [15:0] diff_s;
    logic [15:0] step_s;
    logic [15:0] cur_nx_s;

    // Compare first so the subtraction can never go negative
    always_comb begin
        diff_s   = 16'd0;
        step_s   = 16'd0;
        cur_nx_s = cur_r;
        if (cur_r < i_target) begin
            diff_s   = i_target - cur_r;
            step_s   = (diff_s > RAMP_STEP) ? RAMP_STEP : diff_s;
            cur_nx_s = cur_r + step_s;
        end else if (cur_r > i_target) begin
            diff_s   = cur_r - i_target;
            step_s   = (diff_s > RAMP_STEP) ? RAMP_STEP : diff_s;
            cur_nx_s = cur_r - step_s;
        end else begin
            cur_nx_s = cur_r;
        end
    end

    // Current gain register, advanced only on a ramp tick
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cur_r <= 16'd0;
        end else if (i_tick) begin
            cur_r <= cur_nx_s;
        end else begin
            cur_r <= cur_r;
        end
    end

    assign o_cur       = cur_r;
    assign o_at_target = (cur_r == i_target);

endmodule

// File: rtl/fm_tx_ctrl.sv
// FM mixer configuration sequencer: accepts single config writes and applies
// them click-free (slewed gains, mute-retune-settle-unmute for frequency).
module fm_tx_ctrl
    import fm_ctrl_pkg::*;
#(
    parameter int unsigned RAMP_DIV   = 50,
    parameter logic [15:0] RAMP_STEP  = 16'd64,
    parameter int unsigned SETTLE_CYC = 5000,
    parameter logic [31:0] RST_FREQ   = 32'd0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cfg_valid,
    output logic        o_cfg_ready,
    input  logic [1:0]  i_cfg_sel,
    input  logic [31:0] i_cfg_data,
    output logic [31:0] o_rf_freq,
    output logic [15:0] o_audio_gain,
    output logic [15:0] o_pilot_gain,
    output logic        o_busy,
    output logic        o_muted
);

    localparam logic [15:0] DIV_LAST    = 16'(RAMP_DIV - 32'd1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 32'd1);

    state_e      state_r;
    state_e      state_nx_s;
    logic        ready_r;
    logic        busy_r;
    logic        mute_r;
    logic [31:0] freq_r;
    logic [31:0] pend_freq_r;
    logic [31:0] settle_cnt_r;
    logic [15:0] div_cnt_r;
    logic [15:0] a_tgt_r;
    logic [15:0] p_tgt_r;
    logic [15:0] a_eff_s;
    logic [15:0] p_eff_s;
    logic        xfer_s;
    logic        ramping_s;
    logic        tick_s;
    logic        a_at_s;
    logic        p_at_s;

    assign xfer_s = i_cfg_valid & ready_r;
    assign tick_s = ramping_s & (div_cnt_r == DIV_LAST);

    // Ramp-state decode and effective gain targets (mute or retune force zero)
    always_comb begin
        ramping_s = 1'b0;
        a_eff_s   = a_tgt_r;
        p_eff_s   = p_tgt_r;
        case (state_r)
            RAMP, RAMP_DN, RAMP_UP: ramping_s = 1'b1;
            default:                ramping_s = 1'b0;
        endcase
        if ((state_r == RAMP_DN) || mute_r) begin
            a_eff_s = 16'd0;
            p_eff_s = 16'd0;
        end else begin
            a_eff_s = a_tgt_r;
            p_eff_s = p_tgt_r;
        end
    end

    // Sequencer next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:          state_nx_s = !xfer_s ? IDLE :
                                        (i_cfg_sel == SEL_FREQ) ? RAMP_DN : RAMP;
            RAMP, RAMP_UP: state_nx_s = (a_at_s && p_at_s) ? IDLE : state_r;
            RAMP_DN:       state_nx_s = (a_at_s && p_at_s) ? TUNE : RAMP_DN;
            TUNE:          state_nx_s = SETTLE;
            SETTLE:        state_nx_s = (settle_cnt_r == SETTLE_LAST) ? RAMP_UP : SETTLE;
            default:       state_nx_s = IDLE;
        endcase
    end

    // State register with handshake outputs registered from the next state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ready_r <= (state_nx_s == IDLE);
            busy_r  <= (state_nx_s != IDLE);
        end
    end

    // Configuration registers; the frequency is only parked until TUNE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend_freq_r <= 32'd0;
            a_tgt_r     <= 16'd0;
            p_tgt_r     <= 16'd0;
            mute_r      <= 1'b0;
        end else if (xfer_s) begin
            case (i_cfg_sel)
                SEL_FREQ:  pend_freq_r <= i_cfg_data;
                SEL_AGAIN: a_tgt_r     <= i_cfg_data[15:0];
                SEL_PGAIN: p_tgt_r     <= i_cfg_data[15:0];
                SEL_MUTE:  mute_r      <= i_cfg_data[0];
                default:   mute_r      <= mute_r;
            endcase
        end
    end

    // NCO word moves only in TUNE, when both gains are already at zero
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            freq_r <= RST_FREQ;
        end else if (state_r == TUNE) begin
            freq_r <= pend_freq_r;
        end
    end

    // Ramp divider held at zero outside ramp states so each entry restarts it
    always_ff @(posedge i_clk) begin
        if (i_rst || !ramping_s || tick_s) begin
            div_cnt_r <= 16'd0;
        end else begin
            div_cnt_r <= div_cnt_r + 16'd1;
        end
    end

    // Settle counter runs only while muted after a retune
    always_ff @(posedge i_clk) begin
        if (i_rst || (state_r != SETTLE)) begin
            settle_cnt_r <= 32'd0;
        end else begin
            settle_cnt_r <= settle_cnt_r + 32'd1;
        end
    end

    gain_slew #(.RAMP_STEP(RAMP_STEP)) u_audio (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_tick      (tick_s),
        .i_target    (a_eff_s),
        .o_cur       (o_audio_gain),
        .o_at_target (a_at_s)
    );

    gain_slew #(.RAMP_STEP(RAMP_STEP)) u_pilot (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_tick      (tick_s),
        .i_target    (p_eff_s),
        .o_cur       (o_pilot_gain),
        .o_at_target (p_at_s)
    );

    assign o_cfg_ready = ready_r;
    assign o_busy      = busy_r;
    assign o_rf_freq   = freq_r;
    assign o_muted     = mute_r;

endmodule

// File: tb/tb_fm_tx_ctrl.sv
// Self-checking bench for fm_tx_ctrl: table of config writes with final-state
// expectations, a scoreboard of expected gain/frequency steps, and corner cases.
module tb_fm_tx_ctrl;

    localparam logic [15:0] STEP = 16'd64;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [1:0]  sel;
    logic [31:0] data;
    logic        o_cfg_ready;
    logic [31:0] o_rf_freq;
    logic [15:0] o_audio_gain;
    logic [15:0] o_pilot_gain;
    logic        o_busy;
    logic        o_muted;

    always #5 clk = ~clk;

    fm_tx_ctrl #(
        .RAMP_DIV   (1),
        .RAMP_STEP  (16'd64),
        .SETTLE_CYC (4),
        .RST_FREQ   (32'h1000)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cfg_valid  (valid),
        .o_cfg_ready  (o_cfg_ready),
        .i_cfg_sel    (sel),
        .i_cfg_data   (data),
        .o_rf_freq    (o_rf_freq),
        .o_audio_gain (o_audio_gain),
        .o_pilot_gain (o_pilot_gain),
        .o_busy       (o_busy),
        .o_muted      (o_muted)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level model and scoreboard queues
    logic [15:0] m_a = 16'd0, m_p = 16'd0, m_at = 16'd0, m_pt = 16'd0;
    logic        m_mute = 1'b0;
    logic [31:0] m_freq = 32'h1000;
    logic [15:0] exp_a[$];
    logic [15:0] exp_p[$];
    logic [31:0] exp_f[$];

    function automatic logic [15:0] step_to(input logic [15:0] c, input logic [15:0] t);
        if (c < t)      return ((t - c) > STEP) ? (c + STEP) : t;
        else if (c > t) return ((c - t) > STEP) ? (c - STEP) : t;
        else            return c;
    endfunction

    task automatic ramp_model(input logic [15:0] ta, input logic [15:0] tp);
        while (m_a != ta) begin m_a = step_to(m_a, ta); exp_a.push_back(m_a); end
        while (m_p != tp) begin m_p = step_to(m_p, tp); exp_p.push_back(m_p); end
    endtask

    task automatic model_write(input logic [1:0] s, input logic [31:0] d);
        case (s)
            2'd0: begin
                ramp_model(16'd0, 16'd0);
                m_freq = d;
                exp_f.push_back(d);
            end
            2'd1:    m_at   = d[15:0];
            2'd2:    m_pt   = d[15:0];
            default: m_mute = d[0];
        endcase
        if (m_mute) ramp_model(16'd0, 16'd0);
        else        ramp_model(m_at, m_pt);
    endtask

    // Monitor: every gain/frequency change must match the next expected step
    logic        mon_en = 1'b0;
    logic [15:0] prev_a = 16'd0, prev_p = 16'd0;
    logic [31:0] prev_f = 32'h1000;
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_audio_gain != prev_a) begin
                if (exp_a.size() == 0) chk("audio_unexpected", {16'd0, o_audio_gain}, {16'd0, prev_a});
                else                   chk("audio_step", {16'd0, o_audio_gain}, {16'd0, exp_a.pop_front()});
            end
            if (o_pilot_gain != prev_p) begin
                if (exp_p.size() == 0) chk("pilot_unexpected", {16'd0, o_pilot_gain}, {16'd0, prev_p});
                else                   chk("pilot_step", {16'd0, o_pilot_gain}, {16'd0, exp_p.pop_front()});
            end
            if (o_rf_freq != prev_f) begin
                chk("freq_while_gain", {16'd0, prev_a | prev_p | o_audio_gain | o_pilot_gain}, 32'd0);
                if (exp_f.size() == 0) chk("freq_unexpected", o_rf_freq, prev_f);
                else                   chk("freq_step", o_rf_freq, exp_f.pop_front());
            end
        end
        prev_a = o_audio_gain;
        prev_p = o_pilot_gain;
        prev_f = o_rf_freq;
    end

    // Drive one write, holding valid until the DUT accepts it
    task automatic do_write(input logic [1:0] s, input logic [31:0] d, output int waited);
        logic r;
        logic done;
        waited = 0;
        done   = 1'b0;
        @(negedge clk);
        valid = 1'b1; sel = s; data = d;
        for (int i = 0; i < 5000 && !done; i++) begin
            r = o_cfg_ready;
            @(posedge clk); #1;
            if (r) done = 1'b1;
            else   waited++;
        end
        if (done) model_write(s, d);
        else      chk("write_timeout", 32'd0, 32'd1);
        valid = 1'b0;
    endtask

    task automatic wait_idle(output int lat);
        lat = 0;
        while (!o_cfg_ready && lat < 5000) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!o_cfg_ready) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
        logic [15:0] a;
        logic [15:0] p;
        logic [31:0] f;
        logic        m;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int w;
        int lat;
        rst = 1'b1; valid = 1'b0; sel = 2'd0; data = 32'd0;

        vecs[0]  = '{2'd1, 32'd200,     16'd200, 16'd0,      32'h1000, 1'b0, 5};
        vecs[1]  = '{2'd2, 32'd100,     16'd200, 16'd100,    32'h1000, 1'b0, -1};
        vecs[2]  = '{2'd0, 32'h2000,    16'd200, 16'd100,    32'h2000, 1'b0, 15};
        vecs[3]  = '{2'd3, 32'd1,       16'd0,   16'd0,      32'h2000, 1'b1, -1};
        vecs[4]  = '{2'd1, 32'd500,     16'd0,   16'd0,      32'h2000, 1'b1, 1};
        vecs[5]  = '{2'd3, 32'd0,       16'd500, 16'd100,    32'h2000, 1'b0, -1};
        vecs[6]  = '{2'd2, 32'hFFC0,    16'd500, 16'hFFC0,   32'h2000, 1'b0, -1};
        vecs[7]  = '{2'd2, 32'hFFF0,    16'd500, 16'hFFF0,   32'h2000, 1'b0, 2};
        vecs[8]  = '{2'd2, 32'hFFFF,    16'd500, 16'hFFFF,   32'h2000, 1'b0, 2};
        vecs[9]  = '{2'd2, 32'd0,       16'd500, 16'd0,      32'h2000, 1'b0, -1};
        vecs[10] = '{2'd1, 32'd500,     16'd500, 16'd0,      32'h2000, 1'b0, 1};
        vecs[11] = '{2'd0, 32'h3000,    16'd500, 16'd0,      32'h3000, 1'b0, -1};
        vecs[12] = '{2'd1, 32'd0,       16'd0,   16'd0,      32'h3000, 1'b0, -1};
        vecs[13] = '{2'd0, 32'h4000,    16'd0,   16'd0,      32'h4000, 1'b0, 7};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_freq",  o_rf_freq,              32'h1000);
        chk("rst_audio", {16'd0, o_audio_gain},  32'd0);
        chk("rst_pilot", {16'd0, o_pilot_gain},  32'd0);
        chk("rst_ready", {31'd0, o_cfg_ready},   32'd1);
        chk("rst_busy",  {31'd0, o_busy},        32'd0);
        chk("rst_muted", {31'd0, o_muted},       32'd0);
        mon_en = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_write(vecs[i].sel, vecs[i].data, w);
            if (vecs[i].sel == 2'd3) chk("mute_immediate", {31'd0, o_muted}, {31'd0, vecs[i].data[0]});
            wait_idle(lat);
            chk($sformatf("v%0d_audio", i), {16'd0, o_audio_gain}, {16'd0, vecs[i].a});
            chk($sformatf("v%0d_pilot", i), {16'd0, o_pilot_gain}, {16'd0, vecs[i].p});
            chk($sformatf("v%0d_freq", i),  o_rf_freq, vecs[i].f);
            chk($sformatf("v%0d_muted", i), {31'd0, o_muted}, {31'd0, vecs[i].m});
            chk($sformatf("v%0d_busy", i),  {31'd0, o_busy}, 32'd0);
            if (vecs[i].lat >= 0) chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
        end

        // Write presented while busy is held off, then taken exactly once
        do_write(2'd2, 32'd200, w);
        do_write(2'd1, 32'd100, w);
        chk("held_wait_cycles", w, 32'd5);
        chk("held_after_pilot", {16'd0, o_pilot_gain}, 32'd200);
        wait_idle(lat);
        chk("held_audio", {16'd0, o_audio_gain}, 32'd100);
        repeat (3) @(posedge clk);
        #1 chk("held_no_repeat", {31'd0, o_cfg_ready}, 32'd1);

        // Reset during SETTLE aborts the retune and clears targets
        do_write(2'd1, 32'd300, w);
        wait_idle(lat);
        do_write(2'd0, 32'h5000, w);
        for (int i = 0; i < 100 && o_rf_freq != 32'h5000; i++) begin
            @(posedge clk); #1;
        end
        chk("settle_reached", o_rf_freq, 32'h5000);
        exp_f.push_back(32'h1000);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("srst_freq",  o_rf_freq,             32'h1000);
        chk("srst_audio", {16'd0, o_audio_gain}, 32'd0);
        chk("srst_pilot", {16'd0, o_pilot_gain}, 32'd0);
        chk("srst_ready", {31'd0, o_cfg_ready},  32'd1);
        chk("srst_busy",  {31'd0, o_busy},       32'd0);
        chk("srst_pending_rampup", exp_a.size(), 32'd5);
        exp_a.delete();
        exp_p.delete();
        m_a = 16'd0; m_p = 16'd0; m_at = 16'd0; m_pt = 16'd0; m_mute = 1'b0; m_freq = 32'h1000;
        do_write(2'd3, 32'd0, w);
        wait_idle(lat);
        chk("srst_targets_cleared", lat, 32'd1);
        repeat (3) @(posedge clk);
        #1 chk("srst_audio_stays", {16'd0, o_audio_gain}, 32'd0);

        @(negedge clk);
        chk("scoreboard_empty", exp_a.size() + exp_p.size() + exp_f.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
